logo_cmd_sequencer: RTL and testbench
=====================================

LOGO_CMD_SEQUENCER -- requirements
Module: logo_cmd_sequencer

Interface
REQ-001 Parameter ENTER_CODE, default 8'h5A, scan code that commits the assembled command.
REQ-002 Parameter BKSP_CODE, default 8'h66, scan code that deletes the newest buffered character.
REQ-003 Port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port key_valid, input, 1, one-cycle pulse marking a new PS2 scan byte.
REQ-006 Port key_data, input, 8, raw PS2 scan byte, qualified by key_valid.
REQ-007 Port cmd_ready, input, 1, processor accepts cmd_word when high together with cmd_valid.
REQ-008 Port cmd_valid, output, 1, committed command available.
REQ-009 Port cmd_word, output, 32, committed ASCII command with the newest character in [7:0], unused upper bytes zero.
REQ-010 Port cmd_len, output, 3, character count of cmd_word (1-4).
REQ-011 Port char_count, output, 3, live count of buffered characters (0-4).
REQ-012 Port busy, output, 1, high while in PENDING.
REQ-013 Port overflow, output, 1, one-cycle pulse when a character is dropped because the buffer is full.

Function
REQ-014 The FSM SHALL have states COLLECT, BREAK, EXT and PENDING.
REQ-015 COLLECT: on key_valid with key_data 8'hF0 -> BREAK; with 8'hE0 -> EXT; otherwise the byte is processed as a make code.
REQ-016 BREAK: the next key_valid byte SHALL be discarded -> COLLECT.
REQ-017 EXT: on a next byte of 8'hF0 -> BREAK; any other byte SHALL be discarded -> COLLECT.
REQ-018 Make code mapping to nonzero ASCII with char_count<4: buffer <= {buffer[23:0], ascii}, char_count+1, one-cycle latency.
REQ-019 Make code mapping to nonzero ASCII with char_count==4: buffer unchanged; overflow pulses the next cycle.
REQ-020 Make codes mapping to ASCII 8'h00 (other than ENTER_CODE/BKSP_CODE) SHALL be ignored.
REQ-021 BKSP_CODE with char_count>0: buffer <= {8'h00, buffer[31:8]}, char_count-1; with char_count==0: no effect.
REQ-022 ENTER_CODE with char_count>0: cmd_word <= buffer, cmd_len <= char_count, buffer and char_count cleared, cmd_valid high the next cycle -> PENDING.
REQ-023 ENTER_CODE with char_count==0 SHALL be ignored; state remains COLLECT.
REQ-024 PENDING: cmd_valid and cmd_word SHALL hold stable until a cycle in which cmd_ready is high; cmd_valid falls the next cycle -> COLLECT.
REQ-025 In PENDING, every key_valid byte SHALL be dropped, including 8'hF0/8'hE0, and SHALL not raise overflow.
REQ-026 key_valid in the same cycle as the accepting handshake SHALL be dropped.
REQ-027 cmd_ready while cmd_valid is low SHALL have no effect.
REQ-028 cmd_word and cmd_len SHALL retain the last committed value after the handshake.

Reset
REQ-029 While reset is high at a clock edge: state=COLLECT, buffer=0, char_count=0, cmd_word=0, cmd_len=0, cmd_valid=0, busy=0, overflow=0.
REQ-030 Reset SHALL take priority over all inputs and SHALL abort any operation immediately, including a pending command, which is lost.

Structure
REQ-031 The state encoding and the 8'hF0/8'hE0 prefix constants SHALL live in a shared package; the ENTER_CODE/BKSP_CODE defaults SHALL be taken from it.
REQ-032 Scan-to-ASCII conversion SHALL reuse the existing combinational mapping module as the only sub-module.

Verification
REQ-033 Keys 1C,32,21 then 5A -> cmd_valid=1, cmd_word=32'h00414243, cmd_len=3; hold until cmd_ready, then cmd_valid=0 and char_count=0.
REQ-034 Sequence 1C,F0,1C,32 -> char_count=2, buffer=16'h4142; the byte after F0 is not buffered.
REQ-035 Five letters 1C,32,21,23,24 -> overflow pulses exactly once; then 5A -> cmd_word=32'h41424344.
REQ-036 Sequence 1C,66,66,5A -> char_count goes 1,0,0; no cmd_valid.
REQ-037 In PENDING, bytes 1C,F0 arrive with cmd_ready=0 -> cmd_word is unchanged and no overflow; after the handshake the next 32 yields char_count=1.
REQ-038 Reset asserted one cycle after 5A while cmd_valid=1 -> all outputs 0 on the next edge; state=COLLECT.

Source files
------------

// File: rtl/logo_cmd_sequencer_pkg.sv
// Shared definitions for the LOGO command sequencer: FSM encoding,
// PS/2 prefix bytes and the default commit/delete scan codes.
package logo_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        BREAK   = 2'd1,
        EXT     = 2'd2,
        PENDING = 2'd3
    } seq_state_t;

    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;

    localparam logic [7:0] DEF_ENTER_CODE = 8'h5A;
    localparam logic [7:0] DEF_BKSP_CODE  = 8'h66;

    localparam int BUF_CHARS = 4;

endpackage

// File: rtl/logo_cmd_sequencer_scan2ascii.sv
// Combinational PS/2 set-2 make code to ASCII map.
// Letters (upper case), digits and space; anything else maps to 8'h00.
module logo_cmd_sequencer_scan2ascii (
    input  logic [7:0] scan_i,
    output logic [7:0] ascii_o
);

    // Table lookup; unknown codes yield zero so the caller can ignore them
    always_comb begin
        ascii_o = 8'h00;
        case (scan_i)
            8'h1C: ascii_o = "A";  8'h32: ascii_o = "B";  8'h21: ascii_o = "C";
            8'h23: ascii_o = "D";  8'h24: ascii_o = "E";  8'h2B: ascii_o = "F";
            8'h34: ascii_o = "G";  8'h33: ascii_o = "H";  8'h43: ascii_o = "I";
            8'h3B: ascii_o = "J";  8'h42: ascii_o = "K";  8'h4B: ascii_o = "L";
            8'h3A: ascii_o = "M";  8'h31: ascii_o = "N";  8'h44: ascii_o = "O";
            8'h4D: ascii_o = "P";  8'h15: ascii_o = "Q";  8'h2D: ascii_o = "R";
            8'h1B: ascii_o = "S";  8'h2C: ascii_o = "T";  8'h3C: ascii_o = "U";
            8'h2A: ascii_o = "V";  8'h1D: ascii_o = "W";  8'h22: ascii_o = "X";
            8'h35: ascii_o = "Y";  8'h1A: ascii_o = "Z";
            8'h45: ascii_o = "0";  8'h16: ascii_o = "1";  8'h1E: ascii_o = "2";
            8'h26: ascii_o = "3";  8'h25: ascii_o = "4";  8'h2E: ascii_o = "5";
            8'h36: ascii_o = "6";  8'h3D: ascii_o = "7";  8'h3E: ascii_o = "8";
            8'h46: ascii_o = "9";  8'h29: ascii_o = " ";
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/logo_cmd_sequencer.sv
// Assembles PS/2 make codes into a 4-character ASCII command and hands it
// to the processor over a valid/ready port.
//
// Handshake: cmd_valid rises with a committed command and, together with
// cmd_word/cmd_len, holds stable until a cycle where cmd_ready is also high;
// that cycle completes the transfer and cmd_valid drops on the next edge.
// cmd_ready while cmd_valid is low is ignored.
module logo_cmd_sequencer
    import logo_cmd_sequencer_pkg::*;
#(
    parameter logic [7:0] ENTER_CODE = DEF_ENTER_CODE,
    parameter logic [7:0] BKSP_CODE  = DEF_BKSP_CODE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_data,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [31:0] cmd_word,
    output logic [2:0]  cmd_len,
    output logic [2:0]  char_count,
    output logic        busy,
    output logic        overflow,
    output logic [1:0]  state_dbg
);

    seq_state_t  state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  len_q, len_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  ascii;

    logo_cmd_sequencer_scan2ascii u_map (
        .scan_i  (key_data),
        .ascii_o (ascii)
    );

    // State and datapath registers; reset drops any pending command
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COLLECT;
            buf_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: prefix tracking, buffer edit, commit and handshake
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        len_d   = len_q;
        ovf_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (key_valid) begin
                    if (key_data == PS2_BREAK_PREFIX) begin
                        state_d = BREAK;
                    end else if (key_data == PS2_EXT_PREFIX) begin
                        state_d = EXT;
                    end else if (key_data == ENTER_CODE) begin
                        if (cnt_q != 3'd0) begin
                            word_d  = buf_q;
                            len_d   = cnt_q;
                            buf_d   = '0;
                            cnt_d   = '0;
                            state_d = PENDING;
                        end
                    end else if (key_data == BKSP_CODE) begin
                        if (cnt_q != 3'd0) begin
                            buf_d = {8'h00, buf_q[31:8]};
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (ascii != 8'h00) begin
                        if (cnt_q < 3'(BUF_CHARS)) begin
                            buf_d = {buf_q[23:0], ascii};
                            cnt_d = cnt_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            BREAK: begin
                // The released key's code is not a new character
                if (key_valid) state_d = COLLECT;
            end
            EXT: begin
                if (key_valid) begin
                    state_d = (key_data == PS2_BREAK_PREFIX) ? BREAK : COLLECT;
                end
            end
            PENDING: begin
                // Keys arriving here, including prefixes, are dropped
                if (cmd_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    assign cmd_valid  = (state_q == PENDING);
    assign busy       = (state_q == PENDING);
    assign cmd_word   = word_q;
    assign cmd_len    = len_q;
    assign char_count = cnt_q;
    assign overflow   = ovf_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_logo_cmd_sequencer.sv
// Directed bench for logo_cmd_sequencer. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, after the edge has settled.
module tb_logo_cmd_sequencer;
    import logo_cmd_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_data = 8'h00;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [31:0] cmd_word;
    logic [2:0]  cmd_len;
    logic [2:0]  char_count;
    logic        busy;
    logic        overflow;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int ovf_pulses = 0;

    logo_cmd_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_word   (cmd_word),
        .cmd_len    (cmd_len),
        .char_count (char_count),
        .busy       (busy),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial forever #5 clock = ~clock;

    // Overflow pulse counter, sampled on the falling edge
    always @(negedge clock) if (overflow === 1'b1) ovf_pulses++;

    // Driver tasks
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic send_key(input logic [7:0] b);
        key_valid = 1'b1; key_data = b;
        tick();
        key_valid = 1'b0; key_data = 8'h00;
    endtask

    task automatic handshake();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", cmd_valid); end
        checks++; if (cmd_word !== 32'h0) begin errors++; $display("FAIL rst_word: got %h exp 00000000", cmd_word); end
        checks++; if (cmd_len !== 3'd0) begin errors++; $display("FAIL rst_len: got %0d exp 0", cmd_len); end
        checks++; if (char_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", char_count); end
        checks++; if ({busy, overflow} !== 2'b00) begin errors++; $display("FAIL rst_busy_ovf: got %b exp 00", {busy, overflow}); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", state_dbg); end
    endtask

    task automatic test_basic_commit();
        send_key(8'h1C); send_key(8'h32); send_key(8'h21);
        checks++; if (char_count !== 3'd3) begin errors++; $display("FAIL basic_count: got %0d exp 3", char_count); end
        send_key(8'h5A);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", cmd_valid); end
        checks++; if (cmd_word !== 32'h00414243) begin errors++; $display("FAIL basic_word: got %h exp 00414243", cmd_word); end
        checks++; if (cmd_len !== 3'd3) begin errors++; $display("FAIL basic_len: got %0d exp 3", cmd_len); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy); end
        checks++; if (char_count !== 3'd0) begin errors++; $display("FAIL basic_clear: got %0d exp 0", char_count); end
        tick(); tick(); tick();
        checks++; if ({cmd_valid, cmd_word} !== {1'b1, 32'h00414243}) begin errors++; $display("FAIL basic_hold: got %b/%h exp 1/00414243", cmd_valid, cmd_word); end
        handshake();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b exp 0", cmd_valid); end
        checks++; if (char_count !== 3'd0) begin errors++; $display("FAIL basic_count_after: got %0d exp 0", char_count); end
        checks++; if ({cmd_word, cmd_len} !== {32'h00414243, 3'd3}) begin errors++; $display("FAIL basic_retain: got %h/%0d exp 00414243/3", cmd_word, cmd_len); end
    endtask

    task automatic test_break();
        send_key(8'h1C); send_key(8'hF0); send_key(8'h1C); send_key(8'h32);
        checks++; if (char_count !== 3'd2) begin errors++; $display("FAIL break_count: got %0d exp 2", char_count); end
        send_key(8'h5A);
        checks++; if ({cmd_word, cmd_len} !== {32'h00004142, 3'd2}) begin errors++; $display("FAIL break_word: got %h/%0d exp 00004142/2", cmd_word, cmd_len); end
        handshake();
    endtask

    task automatic test_overflow();
        ovf_pulses = 0;
        send_key(8'h1C); send_key(8'h32); send_key(8'h21); send_key(8'h23);
        checks++; if ({char_count, overflow} !== {3'd4, 1'b0}) begin errors++; $display("FAIL ovf_full: got %0d/%b exp 4/0", char_count, overflow); end
        send_key(8'h24);
        checks++; if ({char_count, overflow} !== {3'd4, 1'b1}) begin errors++; $display("FAIL ovf_pulse: got %0d/%b exp 4/1", char_count, overflow); end
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
        checks++; if (ovf_pulses != 1) begin errors++; $display("FAIL ovf_once: got %0d pulses exp 1", ovf_pulses); end
        send_key(8'h5A);
        checks++; if ({cmd_word, cmd_len} !== {32'h41424344, 3'd4}) begin errors++; $display("FAIL ovf_word: got %h/%0d exp 41424344/4", cmd_word, cmd_len); end
        handshake();
    endtask

    task automatic test_backspace();
        send_key(8'h1C);
        checks++; if (char_count !== 3'd1) begin errors++; $display("FAIL bksp_1: got %0d exp 1", char_count); end
        send_key(8'h66);
        checks++; if (char_count !== 3'd0) begin errors++; $display("FAIL bksp_0: got %0d exp 0", char_count); end
        send_key(8'h66);
        checks++; if (char_count !== 3'd0) begin errors++; $display("FAIL bksp_empty: got %0d exp 0", char_count); end
        send_key(8'h5A);
        checks++; if ({cmd_valid, busy} !== 2'b00) begin errors++; $display("FAIL enter_empty: got %b exp 00", {cmd_valid, busy}); end
        // Delete newest of three, then commit: A,B,C -> A,B shifted down
        send_key(8'h1C); send_key(8'h32); send_key(8'h21); send_key(8'h66); send_key(8'h5A);
        checks++; if ({cmd_word, cmd_len} !== {32'h00004142, 3'd2}) begin errors++; $display("FAIL bksp_word: got %h/%0d exp 00004142/2", cmd_word, cmd_len); end
        handshake();
    endtask

    task automatic test_ext_and_ignored();
        send_key(8'hE0); send_key(8'h1C);
        checks++; if (char_count !== 3'd0) begin errors++; $display("FAIL ext_discard: got %0d exp 0", char_count); end
        send_key(8'hE0); send_key(8'hF0); send_key(8'h1C);
        checks++; if (char_count !== 3'd0) begin errors++; $display("FAIL ext_break: got %0d exp 0", char_count); end
        send_key(8'h32); send_key(8'h76);
        checks++; if (char_count !== 3'd1) begin errors++; $display("FAIL ignored_code: got %0d exp 1", char_count); end
        send_key(8'h66);
    endtask

    task automatic test_pending_drop();
        send_key(8'h21); send_key(8'h5A);
        send_key(8'h1C); send_key(8'hF0);
        checks++; if ({cmd_valid, cmd_word} !== {1'b1, 32'h00000043}) begin errors++; $display("FAIL pend_word: got %b/%h exp 1/00000043", cmd_valid, cmd_word); end
        checks++; if ({char_count, overflow} !== {3'd0, 1'b0}) begin errors++; $display("FAIL pend_drop: got %0d/%b exp 0/0", char_count, overflow); end
        // Key in the handshake cycle is dropped too
        cmd_ready = 1'b1; key_valid = 1'b1; key_data = 8'h1C;
        tick();
        cmd_ready = 1'b0; key_valid = 1'b0; key_data = 8'h00;
        checks++; if ({cmd_valid, char_count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL hs_key_drop: got %b/%0d exp 0/0", cmd_valid, char_count); end
        send_key(8'h32);
        checks++; if (char_count !== 3'd1) begin errors++; $display("FAIL after_hs: got %0d exp 1", char_count); end
        handshake();
        checks++; if ({cmd_valid, char_count, state_dbg} !== {1'b0, 3'd1, 2'd0}) begin errors++; $display("FAIL idle_ready: got %b/%0d/%0d exp 0/1/0", cmd_valid, char_count, state_dbg); end
        send_key(8'h66);
    endtask

    task automatic test_reset_pending();
        send_key(8'h1C); send_key(8'h5A);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rp_valid: got %b exp 1", cmd_valid); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if ({cmd_valid, busy, overflow, cmd_len, char_count} !== 9'd0) begin errors++; $display("FAIL rp_outputs: got %b exp 0", {cmd_valid, busy, overflow, cmd_len, char_count}); end
        checks++; if ({cmd_word, state_dbg} !== 34'd0) begin errors++; $display("FAIL rp_word_state: got %h/%0d exp 0/0", cmd_word, state_dbg); end
        send_key(8'h32); send_key(8'h5A);
        checks++; if ({cmd_word, cmd_len} !== {32'h00000042, 3'd1}) begin errors++; $display("FAIL rp_fresh: got %h/%0d exp 00000042/1", cmd_word, cmd_len); end
        handshake();
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_commit();
        test_break();
        test_overflow();
        test_backspace();
        test_ext_and_ignored();
        test_pending_drop();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog in case a task stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 ns");
        $fatal(1);
    end

endmodule
